// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX frame arbiter.
package eth_tx_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned GAP_W       = 8;
    localparam int unsigned IFG_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

    // One AXIS beat as seen on the merged output.
    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic              tlast;
        logic              tuser;
    } axis_beat_t;

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// Source-side and merged-side AXIS byte streams of the TX frame arbiter.
interface eth_tx_frame_arbiter_if #(
    parameter int unsigned NUM_SRC = 2
) ();
    import eth_tx_pkg::*;

    logic [DATA_W*NUM_SRC-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]        s_axis_tvalid;
    logic [NUM_SRC-1:0]        s_axis_tlast;
    logic [NUM_SRC-1:0]        s_axis_tuser;
    logic [NUM_SRC-1:0]        s_axis_tready;

    logic [DATA_W-1:0]         m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic                      m_axis_tuser;
    logic                      m_axis_tready;

    // Arbiter side: consumes the sources, drives the merged stream.
    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    // Environment side: drives the sources, consumes the merged stream.
    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

endinterface

// File: rtl/eth_rr_sel.sv
// Round-robin selector: first requester after the last granted index.
module eth_rr_sel #(
    parameter  int unsigned NUM_SRC = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan last+1 .. last+NUM_SRC (mod NUM_SRC); the first hit wins.
    always_comb begin
        int unsigned cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            cand = (32'(last) + off) % NUM_SRC;
            if (!any && req[IDX_W'(cand)]) begin
                any                = 1'b1;
                idx                = IDX_W'(cand);
                gnt[IDX_W'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin merge of NUM_SRC AXIS byte sources with inter-frame gap.
module eth_tx_frame_arbiter
    import eth_tx_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned IFG_CYCLES = IFG_DEFAULT
) (
    input  logic                     m_clk_i,
    input  logic                     m_rstn_i,
    input  logic                     en_i,
    eth_tx_frame_arbiter_if.master   bus,
    output logic [NUM_SRC-1:0]       grant_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         frame_cnt_o,
    output logic [CNT_W-1:0]         err_cnt_o
);

    localparam int unsigned IDX_W    = $clog2(NUM_SRC);
    localparam int unsigned GAP_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [NUM_SRC-1:0] rr_gnt;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;

    axis_beat_t         sel_beat;
    logic               sel_valid;
    logic               beat;

    eth_rr_sel #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_sel (
        .req  (bus.s_axis_tvalid),
        .last (last_q),
        .gnt  (rr_gnt),
        .idx  (rr_idx),
        .any  (rr_any)
    );

    // Output mux: in XFER the owner (last_q) is wired straight through; otherwise all quiet.
    always_comb begin
        sel_beat           = '0;
        sel_valid          = 1'b0;
        bus.m_axis_tdata   = '0;
        bus.m_axis_tvalid  = 1'b0;
        bus.m_axis_tlast   = 1'b0;
        bus.m_axis_tuser   = 1'b0;
        bus.s_axis_tready  = '0;
        if (state_q == XFER) begin
            sel_beat.tdata    = bus.s_axis_tdata[{last_q, 3'b000} +: DATA_W];
            sel_beat.tlast    = bus.s_axis_tlast[last_q];
            sel_beat.tuser    = bus.s_axis_tuser[last_q];
            sel_valid         = bus.s_axis_tvalid[last_q];
            bus.m_axis_tdata  = sel_beat.tdata;
            bus.m_axis_tvalid = sel_valid;
            bus.m_axis_tlast  = sel_beat.tlast;
            bus.m_axis_tuser  = sel_beat.tuser;
            bus.s_axis_tready[last_q] = bus.m_axis_tready;
        end
    end

    assign beat = sel_valid & bus.m_axis_tready;

    // Next-state, grant, gap timer and frame/error accounting.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        gap_d       = gap_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && rr_any) begin
                    state_d = XFER;
                    grant_d = rr_gnt;
                    last_d  = rr_idx;
                    err_d   = 1'b0;
                end
            end
            XFER: begin
                if (beat) begin
                    if (sel_beat.tuser) begin
                        err_d = 1'b1;
                    end
                    if (sel_beat.tlast) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        if (err_q || sel_beat.tuser) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (IFG_CYCLES != 0) begin
                            state_d = GAP;
                            gap_d   = GAP_W'(GAP_LOAD);
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and bookkeeping registers; source 0 wins the first arbitration after reset.
    always_ff @(posedge m_clk_i or negedge m_rstn_i) begin
        if (!m_rstn_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= IDX_W'(NUM_SRC - 1);
            gap_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: IFG=12 instance (a) and IFG=0 instance (b).
module tb_eth_tx_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  grant_a, grant_b;
    logic        busy_a, busy_b;
    logic [15:0] fcnt_a, ecnt_a, fcnt_b, ecnt_b;

    int checks = 0;
    int errors = 0;

    // Source queues for instance a: entry = {tuser, tlast, tdata}.
    logic [9:0]  q0[$];
    logic [9:0]  q1[$];
    // Observed beats: {1'b0, src, tuser, tlast, tdata}.
    logic [11:0] obs[$];
    bit          toggle_rdy;
    int          cyc;
    logic [1:0]  rdy_s, vld_s;
    bit          b_on;
    int          b_idx;

    always #5 clk = ~clk;

    eth_tx_frame_arbiter_if #(.NUM_SRC(2)) bus_a ();
    eth_tx_frame_arbiter_if #(.NUM_SRC(2)) bus_b ();

    eth_tx_frame_arbiter #(.NUM_SRC(2), .IFG_CYCLES(12)) dut_a (
        .m_clk_i     (clk),
        .m_rstn_i    (rst_n),
        .en_i        (en),
        .bus         (bus_a),
        .grant_o     (grant_a),
        .busy_o      (busy_a),
        .frame_cnt_o (fcnt_a),
        .err_cnt_o   (ecnt_a)
    );

    eth_tx_frame_arbiter #(.NUM_SRC(2), .IFG_CYCLES(0)) dut_b (
        .m_clk_i     (clk),
        .m_rstn_i    (rst_n),
        .en_i        (en),
        .bus         (bus_b),
        .grant_o     (grant_b),
        .busy_o      (busy_b),
        .frame_cnt_o (fcnt_b),
        .err_cnt_o   (ecnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [9:0] bt(input logic [7:0] d, input logic l, input logic u);
        return {u, l, d};
    endfunction

    // Present queue heads and downstream ready, then let the combinational paths settle.
    task automatic pre();
        logic [9:0] h0, h1;
        h0 = (q0.size() != 0) ? q0[0] : 10'h000;
        h1 = (q1.size() != 0) ? q1[0] : 10'h000;
        bus_a.s_axis_tvalid = {q1.size() != 0, q0.size() != 0};
        bus_a.s_axis_tdata  = {h1[7:0], h0[7:0]};
        bus_a.s_axis_tlast  = {h1[8], h0[8]};
        bus_a.s_axis_tuser  = {h1[9], h0[9]};
        bus_a.m_axis_tready = toggle_rdy ? ~cyc[0] : 1'b1;
        bus_b.s_axis_tvalid = {1'b0, b_on};
        bus_b.s_axis_tdata  = {8'h00, 8'(b_idx)};
        bus_b.s_axis_tlast  = {1'b0, b_idx[0]};
        bus_b.s_axis_tuser  = 2'b00;
        bus_b.m_axis_tready = 1'b1;
        #1;
    endtask

    // Log the output beat, clock once, retire accepted source bytes.
    task automatic post();
        logic b_beat;
        rdy_s  = bus_a.s_axis_tready;
        vld_s  = bus_a.s_axis_tvalid;
        b_beat = bus_b.s_axis_tvalid[0] & bus_b.s_axis_tready[0];
        if (bus_a.m_axis_tvalid && bus_a.m_axis_tready)
            obs.push_back({1'b0, grant_a[1], bus_a.m_axis_tuser, bus_a.m_axis_tlast, bus_a.m_axis_tdata});
        @(posedge clk);
        #1;
        if (vld_s[0] && rdy_s[0]) void'(q0.pop_front());
        if (vld_s[1] && rdy_s[1]) void'(q1.pop_front());
        if (b_beat) b_idx++;
        cyc++;
    endtask

    task automatic run_idle(input logic [1:0] mask, input int max, input string tag);
        int n;
        n = 0;
        while (!((!mask[0] || q0.size() == 0) && (!mask[1] || q1.size() == 0) && !busy_a) && n < max) begin
            pre();
            post();
            n++;
        end
        chk({tag, "_done"}, 32'(n < max), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        obs.delete();
        toggle_rdy = 0;
        b_on       = 0;
        b_idx      = 0;
        pre();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  t1_d [4];
        logic [7:0]  t2_base [4];
        logic [11:0] expv;
        int          gap_n;
        int          lasts;

        t1_d    = '{8'h11, 8'h22, 8'h33, 8'h44};
        t2_base = '{8'hA0, 8'hC0, 8'hB0, 8'hD0};
        en      = 1'b1;
        cyc     = 0;

        // Reset state
        do_reset();
        pre();
        chk("rst_grant", grant_a, 2'b00);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_fcnt", fcnt_a, 16'h0000);
        chk("rst_ecnt", ecnt_a, 16'h0000);
        chk("rst_mvalid", bus_a.m_axis_tvalid, 1'b0);
        chk("rst_sready", bus_a.s_axis_tready, 2'b00);
        chk("rst_grant_b", grant_b, 2'b00);
        post();

        // Single 4-byte frame on src0, then 12-cycle gap
        q0 = '{bt(8'h11, 0, 0), bt(8'h22, 0, 0), bt(8'h33, 0, 0), bt(8'h44, 1, 0)};
        for (int c = 0; c < 5; c++) begin
            pre();
            if (c == 0) begin
                chk("t1_lat_mvalid", bus_a.m_axis_tvalid, 1'b0);
                chk("t1_lat_grant", grant_a, 2'b00);
            end else begin
                chk("t1_mvalid", bus_a.m_axis_tvalid, 1'b1);
                chk("t1_data", bus_a.m_axis_tdata, t1_d[c-1]);
                chk("t1_last", bus_a.m_axis_tlast, 32'(c == 4));
                chk("t1_sready", bus_a.s_axis_tready, 2'b01);
                chk("t1_grant", grant_a, 2'b01);
            end
            post();
        end
        gap_n = 0;
        for (int i = 0; i < 20; i++) begin
            pre();
            if (i == 0) begin
                chk("t1_fcnt", fcnt_a, 16'd1);
                chk("t1_gap_grant", grant_a, 2'b01);
                chk("t1_gap_mvalid", bus_a.m_axis_tvalid, 1'b0);
                chk("t1_gap_sready", bus_a.s_axis_tready, 2'b00);
            end
            if (busy_a) gap_n++;
            post();
        end
        chk("t1_gap_len", gap_n, 12);
        chk("t1_idle_grant", grant_a, 2'b00);

        // Both sources saturated: order 0,1,0,1, frames atomic
        do_reset();
        q0 = '{bt(8'hA0, 0, 0), bt(8'hA1, 0, 0), bt(8'hA2, 1, 0),
               bt(8'hB0, 0, 0), bt(8'hB1, 0, 0), bt(8'hB2, 1, 0)};
        q1 = '{bt(8'hC0, 0, 0), bt(8'hC1, 0, 0), bt(8'hC2, 1, 0),
               bt(8'hD0, 0, 0), bt(8'hD1, 0, 0), bt(8'hD2, 1, 0)};
        run_idle(2'b11, 300, "t2");
        chk("t2_nbeats", obs.size(), 12);
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 3; i++) begin
                expv = {1'b0, 1'(f % 2), 1'b0, 1'(i == 2), t2_base[f] + 8'(i)};
                if (obs.size() > f * 3 + i) chk("t2_beat", obs[f*3+i], expv);
            end
        end
        chk("t2_fcnt", fcnt_a, 16'd4);

        // Downstream ready toggling on a 5-byte src1 frame
        obs.delete();
        q1 = '{bt(8'h61, 0, 0), bt(8'h62, 0, 0), bt(8'h63, 0, 0), bt(8'h64, 0, 0), bt(8'h65, 1, 0)};
        toggle_rdy = 1;
        cyc = 0;
        for (int i = 0; i < 30 && q1.size() != 0; i++) begin
            pre();
            if (bus_a.m_axis_tvalid)
                chk("t3_sready_mirror", bus_a.s_axis_tready, {bus_a.m_axis_tready, 1'b0});
            post();
        end
        chk("t3_drained", q1.size(), 0);
        toggle_rdy = 0;
        run_idle(2'b10, 40, "t3");
        chk("t3_nbeats", obs.size(), 5);
        lasts = 0;
        foreach (obs[i]) begin
            chk("t3_beat", obs[i], {1'b0, 1'b1, 1'b0, 1'(i == 4), 8'h61 + 8'(i)});
            lasts += int'(obs[i][8]);
        end
        chk("t3_tlast_once", lasts, 1);

        // tuser on byte 2, then a clean frame
        obs.delete();
        q0 = '{bt(8'h51, 0, 0), bt(8'h52, 0, 1), bt(8'h53, 1, 0)};
        run_idle(2'b01, 40, "t4a");
        chk("t4_nbeats", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("t4_user_b1", obs[0][9], 1'b0);
            chk("t4_user_b2", obs[1][9], 1'b1);
            chk("t4_user_b3", obs[2][9], 1'b0);
        end
        chk("t4_ecnt", ecnt_a, 16'd1);
        chk("t4_fcnt", fcnt_a, 16'd6);
        q0 = '{bt(8'h71, 0, 0), bt(8'h72, 1, 0)};
        run_idle(2'b01, 40, "t4b");
        chk("t4_ecnt_clean", ecnt_a, 16'd1);
        chk("t4_fcnt_clean", fcnt_a, 16'd7);

        // en_i dropped mid-frame with src1 pending
        obs.delete();
        q0 = '{bt(8'h81, 0, 0), bt(8'h82, 0, 0), bt(8'h83, 0, 0), bt(8'h84, 1, 0)};
        pre();
        post();
        pre();
        chk("t5_grant0", grant_a, 2'b01);
        chk("t5_first", bus_a.m_axis_tdata, 8'h81);
        post();
        en = 1'b0;
        q1 = '{bt(8'h91, 0, 0), bt(8'h92, 1, 0)};
        run_idle(2'b01, 60, "t5a");
        chk("t5_fcnt", fcnt_a, 16'd8);
        chk("t5_nbeats", obs.size(), 4);
        if (obs.size() == 4) chk("t5_last_beat", obs[3], {1'b0, 1'b0, 1'b0, 1'b1, 8'h84});
        for (int i = 0; i < 5; i++) begin
            pre();
            chk("t5_blocked_grant", grant_a, 2'b00);
            chk("t5_blocked_busy", busy_a, 1'b0);
            post();
        end
        en = 1'b1;
        pre();
        chk("t5_en_cycle_grant", grant_a, 2'b00);
        post();
        pre();
        chk("t5_src1_grant", grant_a, 2'b10);
        chk("t5_src1_data", bus_a.m_axis_tdata, 8'h91);
        post();
        run_idle(2'b10, 40, "t5b");
        chk("t5_fcnt_end", fcnt_a, 16'd9);

        // IFG=0 instance: preload counter near wrap, back-to-back 2-byte frames
        force dut_b.frame_cnt_q = 16'hFFFE;
        pre();
        post();
        release dut_b.frame_cnt_q;
        pre();
        chk("t6_preload", fcnt_b, 16'hFFFE);
        post();
        b_on  = 1;
        b_idx = 0;
        for (int c = 0; c < 9; c++) begin
            pre();
            chk("t6_mvalid", bus_b.m_axis_tvalid, 32'((c % 3) != 0));
            if ((c % 3) != 0) begin
                chk("t6_data", bus_b.m_axis_tdata, 8'(b_idx));
                chk("t6_last", bus_b.m_axis_tlast, 32'((c % 3) == 2));
            end
            chk("t6_fcnt", fcnt_b, (c < 3) ? 16'hFFFE : (c < 6) ? 16'hFFFF : 16'h0000);
            post();
        end
        b_on = 0;
        pre();
        chk("t6_fcnt_end", fcnt_b, 16'h0001);
        chk("t6_grant_end", grant_b, 2'b00);
        chk("t6_busy_end", busy_b, 1'b0);
        post();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
